// File: rtl/sigdel_pkg.sv
// -----------------------------------------------------------------------------
// sigdel_pkg
// Shared constants and types for the sinc3 sigma-delta decimator.
//   OSR_LOG2   : log2 of the decimation ratio (16)
//   W          : integrator / comb width, 3*OSR_LOG2+1
//   OUT_W      : output sample width, 3*OSR_LOG2
//   SAT_VAL    : largest representable output, used when full scale is clamped
//   comb_state_e : comb sequencer states
// -----------------------------------------------------------------------------
package sigdel_pkg;

  localparam int OSR_LOG2 = 4;
  localparam int W        = 3 * OSR_LOG2 + 1;
  localparam int OUT_W    = 3 * OSR_LOG2;

  localparam logic [OUT_W-1:0] SAT_VAL = 12'hFFF;

  // Frames that must complete before the comb history is trustworthy.
  localparam logic [1:0] WARMUP_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_C1   = 2'd1,
    ST_C2   = 2'd2,
    ST_C3   = 2'd3
  } comb_state_e;

endpackage : sigdel_pkg

// File: rtl/cic_int_stage.sv
// -----------------------------------------------------------------------------
// cic_int_stage
// One W-bit wrapping integrator of the CIC chain.
//   i_clk     : system clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_clr     : synchronous clear (has priority over i_en)
//   i_en      : accumulate enable (modulator sample strobe)
//   i_operand : value added on each enabled cycle
//   o_acc     : registered accumulator value
// Wrap-around modulo 2^W is intentional: the comb differences cancel it.
// -----------------------------------------------------------------------------
module cic_int_stage #(
  parameter int W = sigdel_pkg::W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_operand,
  output logic [W-1:0] o_acc
);

  import sigdel_pkg::*;

  logic [W-1:0] r_acc;

  // Accumulator register: clear wins over accumulate.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= {W{1'b0}};
    end else if (i_clr) begin
      r_acc <= {W{1'b0}};
    end else if (i_en) begin
      r_acc <= r_acc + i_operand;
    end
  end

  assign o_acc = r_acc;

endmodule : cic_int_stage

// File: rtl/sigdel_cic3.sv
// -----------------------------------------------------------------------------
// sigdel_cic3
// Third-order CIC (sinc3) decimator: 1-bit modulator stream in, 12-bit
// unsigned samples out at 1/16 of the modulator sample rate.
//   i_clk    : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_sd_in  : modulator bit (1 = +1, 0 = 0)
//   i_sd_en  : one-cycle sample strobe, i_sd_in consumed only when high
//   i_clr    : synchronous clear of filter state (o_data is kept)
//   o_data   : last decimated sample, held between o_valid pulses
//   o_valid  : one-cycle pulse when o_data updates
//   o_sat    : sticky flag, set when a full-scale 4096 was clamped to 4095
// Integrators run at the sample rate; a four-state sequencer evaluates the
// three comb stages once per frame, one stage per clock.
// -----------------------------------------------------------------------------
module sigdel_cic3 #(
  parameter int OSR_LOG2 = sigdel_pkg::OSR_LOG2,
  parameter int W        = 3 * OSR_LOG2 + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_sd_in,
  input  logic                    i_sd_en,
  input  logic                    i_clr,
  output logic [3*OSR_LOG2-1:0]   o_data,
  output logic                    o_valid,
  output logic                    o_sat
);

  import sigdel_pkg::*;

  localparam int OW = 3 * OSR_LOG2;

  // Integrator chain
  logic [W-1:0]          w_sd_ext;
  logic [W-1:0]          w_i1;
  logic [W-1:0]          w_i2;
  logic [W-1:0]          w_i3;

  // Decimation control
  logic [OSR_LOG2-1:0]   r_dcnt;
  logic                  w_frame_end;
  logic                  r_frame_end;

  // Comb sequencer
  comb_state_e           r_state;
  comb_state_e           w_state_nxt;

  // Comb datapath
  logic [W-1:0]          r_snap;
  logic [W-1:0]          r_d1;
  logic [W-1:0]          r_d2;
  logic [W-1:0]          r_d3;
  logic [W-1:0]          r_c1;
  logic [W-1:0]          r_c2;
  logic [W-1:0]          w_c3;
  logic [OW-1:0]         w_data_clamped;
  logic                  w_clamp_hit;

  // Output side
  logic [1:0]            r_wu;
  logic [OW-1:0]         r_data;
  logic                  r_valid;
  logic                  r_sat;

  assign w_sd_ext = {{(W-1){1'b0}}, i_sd_in};

  // Each stage adds the previous stage's registered (old) value, so the
  // chain is pipelined: two samples of extra delay, identical for all frames.
  cic_int_stage #(.W(W)) u_int1 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (i_clr),
    .i_en      (i_sd_en),
    .i_operand (w_sd_ext),
    .o_acc     (w_i1)
  );

  cic_int_stage #(.W(W)) u_int2 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (i_clr),
    .i_en      (i_sd_en),
    .i_operand (w_i1),
    .o_acc     (w_i2)
  );

  cic_int_stage #(.W(W)) u_int3 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (i_clr),
    .i_en      (i_sd_en),
    .i_operand (w_i2),
    .o_acc     (w_i3)
  );

  // The last sample of a frame is the strobe seen while the counter is at 15.
  assign w_frame_end = i_sd_en & (r_dcnt == {OSR_LOG2{1'b1}});

  // Decimation counter plus a one-cycle delayed frame-end flag; the delay
  // lets the sequencer snapshot i3 after it has absorbed the last sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dcnt      <= {OSR_LOG2{1'b0}};
      r_frame_end <= 1'b0;
    end else if (i_clr) begin
      r_dcnt      <= {OSR_LOG2{1'b0}};
      r_frame_end <= 1'b0;
    end else begin
      r_frame_end <= w_frame_end;
      if (i_sd_en) begin
        r_dcnt <= r_dcnt + {{(OSR_LOG2-1){1'b0}}, 1'b1};
      end
    end
  end

  // Sequencer next-state logic: one comb stage per clock after a frame end.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_frame_end) begin
          w_state_nxt = ST_C1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_C1:   w_state_nxt = ST_C2;
      ST_C2:   w_state_nxt = ST_C3;
      ST_C3:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else if (i_clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Final comb difference; the true result lies in 0..4096, so bit W-1 set
  // means exactly full scale, which does not fit the output word.
  assign w_c3 = r_c2 - r_d3;

  // Clamp full scale to the largest output code.
  always_comb begin
    w_data_clamped = w_c3[OW-1:0];
    w_clamp_hit    = 1'b0;
    if (w_c3[W-1]) begin
      w_data_clamped = SAT_VAL;
      w_clamp_hit    = 1'b1;
    end else begin
      w_data_clamped = w_c3[OW-1:0];
      w_clamp_hit    = 1'b0;
    end
  end

  // Comb pipeline, warm-up counter and output registers. A clear drops any
  // in-flight result but leaves the last published sample on o_data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_snap  <= {W{1'b0}};
      r_d1    <= {W{1'b0}};
      r_d2    <= {W{1'b0}};
      r_d3    <= {W{1'b0}};
      r_c1    <= {W{1'b0}};
      r_c2    <= {W{1'b0}};
      r_wu    <= 2'd0;
      r_data  <= {OW{1'b0}};
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else if (i_clr) begin
      r_snap  <= {W{1'b0}};
      r_d1    <= {W{1'b0}};
      r_d2    <= {W{1'b0}};
      r_d3    <= {W{1'b0}};
      r_c1    <= {W{1'b0}};
      r_c2    <= {W{1'b0}};
      r_wu    <= 2'd0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_frame_end) begin
            r_snap <= w_i3;
          end
        end
        ST_C1: begin
          r_c1 <= r_snap - r_d1;
          r_d1 <= r_snap;
        end
        ST_C2: begin
          r_c2 <= r_c1 - r_d2;
          r_d2 <= r_c1;
        end
        ST_C3: begin
          r_d3 <= r_c2;
          // The comb history only spans real data once three frames are in.
          if (r_wu == WARMUP_DONE) begin
            r_data  <= w_data_clamped;
            r_valid <= 1'b1;
            if (w_clamp_hit) begin
              r_sat <= 1'b1;
            end
          end else begin
            r_wu <= r_wu + 2'd1;
          end
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_sat   = r_sat;

endmodule : sigdel_cic3

// File: tb/tb_sigdel_cic3.sv
// -----------------------------------------------------------------------------
// tb_sigdel_cic3
// Self-checking bench for sigdel_cic3. The reference is a direct sinc3
// convolution (box-16 cubed kernel, two-sample group delay) over the list of
// samples accepted since the last reset/clear; results are scheduled four
// edges after the frame-end strobe and compared every cycle.
// -----------------------------------------------------------------------------
module tb_sigdel_cic3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sd_in = 1'b0;
  logic        sd_en = 1'b0;
  logic        clr   = 1'b0;
  logic [11:0] data;
  logic        valid;
  logic        sat;

  sigdel_cic3 dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_sd_in (sd_in),
    .i_sd_en (sd_en),
    .i_clr   (clr),
    .o_data  (data),
    .o_valid (valid),
    .o_sat   (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
  } pend_t;

  int     checks = 0;
  int     errors = 0;
  int     h[0:45];
  bit     xs[$];
  pend_t  pend[$];
  int     edge_no = 0;
  logic        exp_valid = 1'b0;
  logic [11:0] exp_data  = 12'h000;
  logic        exp_sat   = 1'b0;
  bit     cmp_on = 1'b0;
  int     v_edges[$];
  int     v_data[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference sinc3 output for frame f of the current sample list.
  function automatic int frame_out(input int f);
    int y;
    int idx;
    y = 0;
    for (int j = 0; j < 46; j++) begin
      idx = 16 * f + 13 - j;
      if (idx >= 0 && idx < xs.size()) begin
        y += h[j] * int'(xs[idx]);
      end
    end
    return y;
  endfunction

  function automatic int qat(input int i, input bit want_data);
    if (want_data) begin
      return (i < v_data.size()) ? v_data[i] : -1;
    end
    return (i < v_edges.size()) ? v_edges[i] : -1;
  endfunction

  task automatic model_reset();
    xs.delete();
    pend.delete();
    exp_valid = 1'b0;
    exp_data  = 12'h000;
    exp_sat   = 1'b0;
  endtask

  task automatic model_clr();
    xs.delete();
    pend.delete();
    exp_valid = 1'b0;
    exp_sat   = 1'b0;
  endtask

  // Apply one clock of stimulus and advance the model past that edge.
  task automatic step(input bit en, input bit din, input bit c);
    pend_t p;
    int    f;
    sd_en = en;
    sd_in = din;
    clr   = c;
    @(posedge clk);
    edge_no++;
    exp_valid = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (c) begin
      model_clr();
    end else begin
      if (pend.size() > 0 && pend[0].due == edge_no) begin
        p = pend.pop_front();
        exp_valid = 1'b1;
        if (p.val >= 4096) begin
          exp_data = 12'hFFF;
          exp_sat  = 1'b1;
        end else begin
          exp_data = 12'(p.val);
        end
      end
      if (en) begin
        xs.push_back(din);
        if (xs.size() % 16 == 0) begin
          f = xs.size() / 16 - 1;
          if (f >= 3) begin
            pend.push_back('{due: edge_no + 4, val: frame_out(f)});
          end
        end
      end
    end
    #1;
  endtask

  task automatic clear_log();
    v_edges.delete();
    v_data.delete();
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("valid", int'(valid), int'(exp_valid));
      chk("data", int'(data), int'(exp_data));
      chk("sat", int'(sat), int'(exp_sat));
      if (valid === 1'b1) begin
        v_edges.push_back(edge_no);
        v_data.push_back(int'(data));
      end
    end
  end

  initial begin
    int b2[0:30];
    int sum;
    int fe;
    int avg;

    // Kernel: box16 * box16 * box16
    for (int i = 0; i < 31; i++) b2[i] = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) b2[a + b]++;
    for (int i = 0; i < 46; i++) h[i] = 0;
    for (int a = 0; a < 31; a++)
      for (int b = 0; b < 16; b++) h[a + b] += b2[a];
    sum = 0;
    for (int i = 0; i < 46; i++) sum += h[i];
    chk("kernel_sum", sum, 4096);
    chk("kernel_h0", h[0], 1);
    chk("kernel_peak", h[22], 192);

    // Reset
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_sat", int'(sat), 0);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    // T1: all zeros, continuous strobe
    clear_log();
    fe = 0;
    for (int k = 0; k < 80; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (k == 63) fe = edge_no;
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0);
    chk("t1_nvalid", v_edges.size(), 2);
    chk("t1_latency", qat(0, 1'b0) - fe, 4);
    chk("t1_data", qat(0, 1'b1), 0);
    chk("t1_sat", int'(sat), 0);

    // T2: all ones -> full scale clamped
    step(1'b0, 1'b0, 1'b1);
    clear_log();
    for (int k = 0; k < 88; k++) step(1'b1, 1'b1, 1'b0);
    chk("t2_nvalid", v_edges.size(), 2);
    chk("t2_data0", qat(0, 1'b1), 4095);
    chk("t2_data1", qat(1, 1'b1), 4095);
    chk("t2_sat", int'(sat), 1);

    // T4: clear mid-frame (with a simultaneous strobe)
    step(1'b1, 1'b1, 1'b1);
    chk("t4_sat_cleared", int'(sat), 0);
    clear_log();
    for (int k = 0; k < 48; k++) step(1'b1, bit'($urandom_range(3, 0) == 0), 1'b0);
    chk("t4_hold", int'(data), 4095);
    chk("t4_quiet", v_edges.size(), 0);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, bit'($urandom_range(3, 0) == 0), 1'b0);
      if (k == 15) fe = edge_no;
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0);
    chk("t4_nvalid", v_edges.size(), 1);
    chk("t4_latency", qat(0, 1'b0) - fe, 4);

    // T3: alternating 1,0 with a strobe every third cycle
    step(1'b0, 1'b0, 1'b1);
    clear_log();
    for (int k = 0; k < 96; k++) begin
      step(1'b1, bit'(k % 2 == 0), 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0);
    chk("t3_nvalid", v_edges.size(), 3);
    chk("t3_data0", qat(0, 1'b1), 2048);
    chk("t3_data1", qat(1, 1'b1), 2048);
    chk("t3_data2", qat(2, 1'b1), 2048);
    chk("t3_spacing0", qat(1, 1'b0) - qat(0, 1'b0), 48);
    chk("t3_spacing1", qat(2, 1'b0) - qat(1, 1'b0), 48);

    // T5: 25% duty random stream, 4000 samples
    step(1'b0, 1'b0, 1'b1);
    clear_log();
    for (int k = 0; k < 4000; k++) step(1'b1, bit'($urandom_range(3, 0) == 0), 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0);
    chk("t5_nvalid", v_data.size(), 247);
    sum = 0;
    foreach (v_data[i]) sum += v_data[i];
    avg = (v_data.size() > 0) ? sum / v_data.size() : 0;
    chk("t5_avg_near_1024", int'(avg >= 924 && avg <= 1124), 1);

    // T6: asynchronous reset while the sequencer is in C2
    for (int k = 0; k < 16; k++) step(1'b1, bit'($urandom_range(3, 0) == 0), 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_data", int'(data), 0);
    chk("t6_async_valid", int'(valid), 0);
    chk("t6_async_sat", int'(sat), 0);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    clear_log();
    for (int k = 0; k < 80; k++) begin
      step(1'b1, bit'($urandom_range(3, 0) == 0), 1'b0);
      if (k == 63) fe = edge_no;
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0);
    chk("t6_nvalid", v_edges.size(), 2);
    chk("t6_latency", qat(0, 1'b0) - fe, 4);

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sigdel_cic3

// File: doc/sigdel_cic3.md
# sigdel_cic3

Third-order CIC (sinc3) decimation filter for the sigma-delta front end. It converts the 1-bit modulator bitstream into 12-bit unsigned samples at 1/16 of the modulator sample rate. It sits directly upstream of the ASCII serial transmitter. The transmitter samples `data` at the start of each character frame, so `data` holds stable between `valid` pulses.

## Interface
- `OSR_LOG2`, default 4: decimation ratio 2^OSR_LOG2 = 16. Only 4 is supported because the output width must equal 3*OSR_LOG2.
- `W`, default 13: integrator/comb width, 3*OSR_LOG2+1. Derived; do not override.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `sd_in` in 1: modulator bitstream; 1 = +1, 0 = 0.
- `sd_en` in 1: one-cycle sample strobe; `sd_in` is consumed only when high.
- `clr` in 1: synchronous clear of filter state; `data` is not affected.
- `data` out 12: last decimated sample, unsigned 0..4095.
- `valid` out 1: one-cycle pulse when `data` updates.
- `sat` out 1: sticky; set when a result of 4096 was clamped to 4095. Cleared by reset or `clr`.

## Operation
- Integrators: three W-bit registers `i1`, `i2`, `i3`, pipelined, updated only on `sd_en`:
  - `i1 <= i1 + sd_in`
  - `i2 <= i2 + i1` (old value)
  - `i3 <= i3 + i2` (old value)
  - All wrap modulo 2^W. Wrap is required CIC behaviour; no overflow detection.
- Decimation counter `dcnt` (4 bit):
  - Increments on each `sd_en`.
  - Wraps 15→0.
  - The `sd_en` cycle where `dcnt`==15 is the frame end.
- FSM states: IDLE, C1, C2, C3.
  - IDLE → C1 on frame end. At that edge, the post-update `i3` is captured into `snap`.
  - C1: `c1 = snap - d1`, `d1 <= snap`.
  - C2: `c2 = c1 - d2`, `d2 <= c1`.
  - C3: `c3 = c2 - d3`, `d3 <= c2`. Output is written, then C3 → IDLE.
  - All comb arithmetic is W-bit modulo.
- Output word: `c3` is in 0..4096. 4096 is clamped to 4095 and sets `sat`. Otherwise `data = c3[11:0]`.
- Warm-up: a 2-bit counter `wu` counts completed frames up to 3.
  - `valid` is suppressed and `data` is not written while `wu` < 3.
  - The first `valid` comes from the 4th frame.
- Integrators keep running while the comb FSM is busy. `sd_en` during C1..C3 is processed normally.
- `clr`: zeroes integrators, combs, `dcnt`, `wu`, `sat` and FSM (→IDLE); drops any in-flight result. `clr` wins over a simultaneous `sd_en`.
- Reset values: everything 0, including `data` = 0, `valid` = 0, `sat` = 0, FSM = IDLE. Reset mid-frame or mid-comb discards all partial state.

## Timing
- Latency: `valid` and the new `data` appear on the 4th rising edge after the edge that registers the frame-end `sd_en`.
  - Edge 1: IDLE→C1
  - Edge 2: →C2
  - Edge 3: →C3
  - Edge 4: `data`/`valid` registered
- `valid` is exactly one clk wide. `data` holds until the next `valid`.
- Minimum `sd_en` spacing is 1 cycle (continuous strobe allowed). Frames are at least 16 clk apart, so the FSM (4 cycles) never overlaps itself.
- Group delay of the integrator pipeline is 2 samples. It applies equally to every frame.

## Structure
- Shared package `sigdel_pkg`: `OSR_LOG2`, `W`, `OUT_W`=12, FSM state encodings, saturation constant 4095.
- Sub-module `cic_int_stage`:
  - Ports: W-bit accumulator with `en`, `clr`, input operand, async reset.
  - Instantiated three times.
  - Comb and FSM stay in the top module.

## Test plan
- `sd_in`=0, `sd_en` every cycle, 80 samples → first `valid` after sample 64 with `data`=0x000; no `valid` earlier; `sat`=0.
- `sd_in`=1, `sd_en` every cycle → 4th-frame `data`=0xFFF, `sat`=1 and stays 1; subsequent frames also 0xFFF.
- Alternating 1,0, `sd_en` every 3rd cycle → `data`=0x800 on every valid frame; `valid` spacing exactly 48 clk.
- Random 25%-duty bitstream, `sd_en` every cycle, 4000 samples → each `data` matches a reference sinc3 model (box-16 cubed) within ±0; average near 1024.
- `clr` asserted mid-frame after 2 valid outputs → no `valid` for the next 3 frames; `data` holds the pre-clear value; `sat` cleared.
- `rst_n` pulsed low in state C2 → `data`=0, `valid`=0, FSM IDLE immediately (asynchronous); warm-up restarts; first `valid` after 64 more samples.
